// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the HDMI audio sample scheduler.
package audio_sched_pkg;

    localparam logic [7:0] CHANNEL_STATUS_LENGTH = 8'd192;
    localparam int         SLOTS                 = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        OFFER = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } sample_pair_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Single-clock FIFO of left-justified sample pairs; a push into a full FIFO
// still succeeds when a pop happens in the same cycle.
module audio_sample_fifo
    import audio_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  sample_pair_t push_data,
    input  logic         pop,
    output sample_pair_t pop_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    sample_pair_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Groups buffered stereo sample pairs into HDMI audio sample packets (up to 4)
// and tracks the channel-status frame index. AUDIO_SCHED_FULL_PACK_EN: full packets only.
module audio_sample_scheduler
    import audio_sched_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk_pixel,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_left,
    input  logic [AUDIO_BIT_WIDTH-1:0] sample_right,
    output logic                       packet_valid,
    input  logic                       packet_accept,
    output logic [7:0]                 frame_counter,
    output logic [3:0][1:0][23:0]      audio_sample_word,
    output logic [3:0]                 audio_sample_word_present,
    output logic                       overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef AUDIO_SCHED_FULL_PACK_EN
    localparam int START_THRESH = SLOTS;
`else
    localparam int START_THRESH = 1;
`endif

    sched_state_t  state;
    logic [2:0]    n;
    sample_pair_t  push_data;
    sample_pair_t  head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          drop;
    logic          last_pop;
    logic [8:0]    fc_sum;

    assign push_data.l = 24'(sample_left)  << (24 - AUDIO_BIT_WIDTH);
    assign push_data.r = 24'(sample_right) << (24 - AUDIO_BIT_WIDTH);

    assign fifo_pop = (state == LOAD) && !fifo_empty;
    assign drop     = sample_valid && fifo_full && !fifo_pop;
    // Close the packet on the pop that drains the FIFO so a lone sample
    // reaches OFFER without an extra empty-check cycle.
    assign last_pop = (fifo_count == CW'(1)) && !sample_valid;
    assign fc_sum   = {1'b0, frame_counter} + {6'd0, n};

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk_pixel),
        .rst       (reset),
        .push      (sample_valid),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state                     <= IDLE;
            n                         <= '0;
            packet_valid              <= 1'b0;
            frame_counter             <= '0;
            audio_sample_word         <= '0;
            audio_sample_word_present <= '0;
            overflow                  <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    if (fifo_count >= CW'(START_THRESH)) begin
                        state                     <= LOAD;
                        audio_sample_word         <= '0;
                        audio_sample_word_present <= '0;
                        n                         <= '0;
                    end
                end
                LOAD: begin
                    if (!fifo_empty) begin
                        audio_sample_word[n[1:0]][0]      <= head.l;
                        audio_sample_word[n[1:0]][1]      <= head.r;
                        audio_sample_word_present[n[1:0]] <= 1'b1;
                        n <= n + 3'd1;
                        if (n == 3'd3 || last_pop) begin
                            state        <= OFFER;
                            packet_valid <= 1'b1;
                        end
                    end else if (n != 3'd0) begin
                        state        <= OFFER;
                        packet_valid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (packet_accept) begin
                        frame_counter <= (fc_sum >= {1'b0, CHANNEL_STATUS_LENGTH})
                                         ? 8'(fc_sum - {1'b0, CHANNEL_STATUS_LENGTH})
                                         : fc_sum[7:0];
                        packet_valid  <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler with hand-computed expectations.
module tb_audio_sample_scheduler;

    logic                  clk_pixel = 1'b0;
    logic                  reset;
    logic                  sample_valid;
    logic [15:0]           sample_left;
    logic [15:0]           sample_right;
    logic                  packet_valid;
    logic                  packet_accept;
    logic [7:0]            frame_counter;
    logic [3:0][1:0][23:0] audio_sample_word;
    logic [3:0]            audio_sample_word_present;
    logic                  overflow;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_pixel = ~clk_pixel;

    audio_sample_scheduler #(
        .AUDIO_BIT_WIDTH (16),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk_pixel                 (clk_pixel),
        .reset                     (reset),
        .sample_valid              (sample_valid),
        .sample_left               (sample_left),
        .sample_right              (sample_right),
        .packet_valid              (packet_valid),
        .packet_accept             (packet_accept),
        .frame_counter             (frame_counter),
        .audio_sample_word         (audio_sample_word),
        .audio_sample_word_present (audio_sample_word_present),
        .overflow                  (overflow)
    );

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        sample_valid = 1'b1;
        sample_left  = l;
        sample_right = r;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (packet_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        vectors++;
        if (packet_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: packet_valid=%b want 1", name, packet_valid);
        end
    endtask

    task automatic accept();
        packet_accept = 1'b1;
        step();
        packet_accept = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({packet_valid, frame_counter, audio_sample_word_present, overflow} !== 14'd0 ||
            audio_sample_word !== '0) begin
            errors++;
            $display("FAIL reset_init: pv=%b fc=%0d pres=%b ovf=%b", packet_valid,
                     frame_counter, audio_sample_word_present, overflow);
        end
        strobe(16'h5555, 16'h6666);
        wait_valid("reset_offer");
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        vectors++;
        if ({packet_valid, frame_counter, audio_sample_word_present, overflow} !== 14'd0 ||
            audio_sample_word !== '0) begin
            errors++;
            $display("FAIL reset_mid_offer: pv=%b fc=%0d pres=%b ovf=%b", packet_valid,
                     frame_counter, audio_sample_word_present, overflow);
        end
        // Nothing buffered survives: no packet may appear.
        repeat (4) step();
        vectors++;
        if (packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: pv=%b want 0", packet_valid);
        end
    endtask

    task automatic test_single();
        strobe(16'h1234, 16'hABCD);
        vectors++;
        if (packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_lat1: pv=%b want 0", packet_valid);
        end
        step();
        vectors++;
        if (packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_lat2: pv=%b want 0", packet_valid);
        end
        step();
        vectors++;
        if (packet_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_lat3: pv=%b want 1", packet_valid);
        end
        vectors++;
        if (audio_sample_word_present !== 4'b0001 || audio_sample_word[0][0] !== 24'h123400 ||
            audio_sample_word[0][1] !== 24'hABCD00 || audio_sample_word[1] !== 48'd0 ||
            frame_counter !== 8'd0) begin
            errors++;
            $display("FAIL single_pkt: pres=%b w00=%h w01=%h fc=%0d want 0001 123400 abcd00 0",
                     audio_sample_word_present, audio_sample_word[0][0],
                     audio_sample_word[0][1], frame_counter);
        end
        accept();
        vectors++;
        if (frame_counter !== 8'd1 || packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_acc: fc=%0d pv=%b want 1 0", frame_counter, packet_valid);
        end
    endtask

    // Four back-to-back strobes, then a stall that must hold every output.
    task automatic test_burst(input logic [7:0] fc0, input logic [7:0] fc1);
        for (int i = 0; i < 4; i++) strobe(16'hA000 + 16'(i), 16'hB000 + 16'(i));
        wait_valid("burst");
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (packet_valid !== 1'b1 || audio_sample_word_present !== 4'b1111 ||
                frame_counter !== fc0) begin
                errors++;
                $display("FAIL burst_hold%0d: pv=%b pres=%b fc=%0d want 1 1111 %0d", c,
                         packet_valid, audio_sample_word_present, frame_counter, fc0);
            end
            for (int s = 0; s < 4; s++) begin
                vectors++;
                if (audio_sample_word[s][0] !== {16'hA000 + 16'(s), 8'h00} ||
                    audio_sample_word[s][1] !== {16'hB000 + 16'(s), 8'h00}) begin
                    errors++;
                    $display("FAIL burst_word%0d: l=%h r=%h", s, audio_sample_word[s][0],
                             audio_sample_word[s][1]);
                end
            end
            step();
        end
        accept();
        vectors++;
        if (frame_counter !== fc1) begin
            errors++;
            $display("FAIL burst_fc: fc=%0d want %0d", frame_counter, fc1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 190; i++) begin
            strobe(16'(i), 16'(i));
            wait_valid("wrap_pre");
            accept();
        end
        vectors++;
        if (frame_counter !== 8'd190) begin
            errors++;
            $display("FAIL wrap_pre: fc=%0d want 190", frame_counter);
        end
        test_burst(8'd190, 8'd2);
        strobe(16'h0001, 16'h0002);
        wait_valid("wrap_next");
        vectors++;
        if (frame_counter !== 8'd2 || audio_sample_word_present !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_next: fc=%0d pres=%b want 2 0001", frame_counter,
                     audio_sample_word_present);
        end
        accept();
    endtask

    task automatic test_overflow();
        do_reset();
        strobe(16'h0F00, 16'h0F01);
        wait_valid("ovf_first");
        for (int i = 0; i < 9; i++) strobe(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        vectors++;
        if (overflow !== 1'b1 || packet_valid !== 1'b1 || audio_sample_word_present !== 4'b0001 ||
            audio_sample_word[0][0] !== 24'h0F0000) begin
            errors++;
            $display("FAIL ovf_flag: ovf=%b pv=%b pres=%b w00=%h want 1 1 0001 0f0000", overflow,
                     packet_valid, audio_sample_word_present, audio_sample_word[0][0]);
        end
        accept();
        for (int p = 0; p < 2; p++) begin
            wait_valid("ovf_drain");
            vectors++;
            if (audio_sample_word_present !== 4'b1111 || frame_counter !== 8'(1 + 4 * p)) begin
                errors++;
                $display("FAIL ovf_pkt%0d: pres=%b fc=%0d want 1111 %0d", p,
                         audio_sample_word_present, frame_counter, 1 + 4 * p);
            end
            for (int s = 0; s < 4; s++) begin
                vectors++;
                if (audio_sample_word[s][0] !== {16'h1000 + 16'(4 * p + s), 8'h00} ||
                    audio_sample_word[s][1] !== {16'h2000 + 16'(4 * p + s), 8'h00}) begin
                    errors++;
                    $display("FAIL ovf_word%0d_%0d: l=%h r=%h", p, s, audio_sample_word[s][0],
                             audio_sample_word[s][1]);
                end
            end
            accept();
        end
        repeat (4) step();
        vectors++;
        if (packet_valid !== 1'b0 || overflow !== 1'b1 || frame_counter !== 8'd9) begin
            errors++;
            $display("FAIL ovf_end: pv=%b ovf=%b fc=%0d want 0 1 9", packet_valid, overflow,
                     frame_counter);
        end
    endtask

    task automatic test_full_pack();
        do_reset();
        for (int i = 0; i < 3; i++) strobe(16'hA000 + 16'(i), 16'hB000 + 16'(i));
        repeat (5) step();
        vectors++;
        if (packet_valid !== 1'b0) begin
            errors++;
            $display("FAIL fullpack_wait: pv=%b want 0", packet_valid);
        end
        sample_valid = 1'b1;
        sample_left  = 16'hA003;
        sample_right = 16'hB003;
        step();
        sample_valid = 1'b0;
        wait_valid("fullpack");
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (audio_sample_word_present !== 4'b1111 || audio_sample_word[3][0] !== 24'hA00300 ||
                audio_sample_word[0][1] !== 24'hB00000 || frame_counter !== 8'd0) begin
                errors++;
                $display("FAIL fullpack_hold%0d: pres=%b w30=%h w01=%h fc=%0d", c,
                         audio_sample_word_present, audio_sample_word[3][0],
                         audio_sample_word[0][1], frame_counter);
            end
            step();
        end
        accept();
        vectors++;
        if (frame_counter !== 8'd4) begin
            errors++;
            $display("FAIL fullpack_fc: fc=%0d want 4", frame_counter);
        end
    endtask

    initial begin
        reset         = 1'b1;
        sample_valid  = 1'b0;
        sample_left   = '0;
        sample_right  = '0;
        packet_accept = 1'b0;
        step();
        reset = 1'b0;
        step();
`ifdef AUDIO_SCHED_FULL_PACK_EN
        test_full_pack();
        test_burst(8'd4, 8'd8);
`else
        test_reset();
        test_single();
        test_burst(8'd1, 8'd5);
        test_wrap();
        test_overflow();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/audio_sample_scheduler.md
Name: audio_sample_scheduler

Overview:
- Sits between the audio input path and the HDMI audio sample packet former, in the clk_pixel domain.
- Buffers stereo L-PCM sample pairs in a small FIFO and groups up to 4 pairs into one packet.
- Offers the packet to the data-island packet picker over a valid/accept handshake.
- Tracks the IEC 60958 192-frame channel-status block position (frame_counter) of the first sample in each packet.

Parameters:
- AUDIO_BIT_WIDTH, 16, input sample width (16..24); left-justified into 24-bit words.
- FIFO_DEPTH, 8, sample-pair FIFO entries; power of 2, >= 4.

Ports:
- clk_pixel  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  one-cycle strobe: one new sample pair; already synchronised to clk_pixel
- sample_left  in  AUDIO_BIT_WIDTH  left-channel sample, two's complement
- sample_right  in  AUDIO_BIT_WIDTH  right-channel sample
- packet_valid  out  1  packet outputs hold a complete packet
- packet_accept  in  1  packet picker consumes the packet this cycle
- frame_counter  out  8  channel-status frame index (0..191) of slot 0
- audio_sample_word  out  [3:0][1:0]x24  slot i, channel 0=L / 1=R
- audio_sample_word_present  out  4  slot occupancy mask
- overflow  out  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset values: packet_valid=0, frame_counter=0, all audio_sample_word=0, present=0, overflow=0, FIFO empty, state=IDLE.
- Sample formatting: word = {sample, (24-AUDIO_BIT_WIDTH) zeros}, applied at FIFO write.
- FIFO push:
  - sample_valid while not full writes one entry.
  - sample_valid while full drops the sample and sets overflow; overflow clears only on reset.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - If the FIFO is full and a pop occurs in the same cycle, the push succeeds.
- State machine (IDLE, LOAD, OFFER):
  - IDLE -> LOAD when FIFO count >= start threshold (1, or 4 with the optional feature).
    - Entering LOAD clears the packet registers (words=0, present=0, n=0).
  - LOAD pops one entry per cycle into slot n, sets present[n], and increments n.
    - LOAD -> OFFER after the cycle that fills slot 3, or on the first cycle the FIFO is empty with n >= 1.
    - Samples arriving during LOAD are appended while n < 4.
  - OFFER: packet_valid=1; all packet outputs are held stable until packet_accept.
    - On accept: frame_counter <= (frame_counter + n >= 192) ? frame_counter + n - 192 : frame_counter + n, computed at 9 bits.
    - Same accept cycle: packet_valid <= 0, next state IDLE.
    - packet_accept outside OFFER is ignored.
- present is always thermometer from bit 0 (0001, 0011, 0111, 1111); unused slots read 0.
- Latency: sample_valid into an empty FIFO in IDLE gives packet_valid 3 cycles later (write, IDLE->LOAD, pop) for a single-sample packet.
- Wrap: frame_counter never reaches 192. Example: 190 + 4 -> 2.
- Reset asserted mid-LOAD or mid-OFFER: immediate return to reset values; the buffered samples and the partial packet are discarded.

Optional Feature:
- Macro: AUDIO_SCHED_FULL_PACK_EN.
- Defined: IDLE->LOAD only when count >= 4; every packet has present=1111, so frame_counter always advances by 4. Requires FIFO_DEPTH >= 8.
- Undefined: threshold is 1; packets carry 1..4 samples.

Decomposition:
- Package audio_sched_pkg holds:
  - CHANNEL_STATUS_LENGTH = 8'd192
  - SLOTS = 4
  - typedef enum {IDLE, LOAD, OFFER} sched_state_t
  - typedef struct packed {logic [23:0] l, r;} sample_pair_t
- One sub-module, audio_sample_fifo: synchronous single-clock FIFO of sample_pair_t with count, full, empty, and push/pop.
- The scheduler instantiates audio_sample_fifo and contains the FSM plus the packet registers.

Test Plan:
- Reset check: reset pulse mid-OFFER -> next cycle packet_valid=0, frame_counter=0, present=0000, overflow=0.
- Single sample: sample_left=16'h1234, sample_right=16'hABCD, one strobe ->
  - 3 cycles later packet_valid=1, present=0001, word[0][0]=24'h123400, word[0][1]=24'hABCD00.
  - After accept, frame_counter=1.
- Burst of 4 strobes on consecutive cycles before LOAD -> one packet with present=1111 and words in order; accept advances frame_counter by 4.
- Wrap: preload frame_counter=190 via 190 single-sample packets, then a 4-sample packet -> that packet reports frame_counter=190; next packet reports 2.
- Overflow: 9 strobes with packet_accept held 0 after the first packet is in OFFER -> overflow=1 and FIFO count=8; accept and drain -> no corrupted words.
- Back-pressure with AUDIO_SCHED_FULL_PACK_EN defined: 3 strobes -> packet_valid stays 0; 4th strobe -> present=1111; outputs stable across 5 stalled cycles before accept.
